// File: rtl/wb_stage.sv
// Writeback stage: a single pipeline register between MEM and the regfile write port,
// with load formatting, load-fault flagging, EX forwarding and a retired-instruction counter.
module wb_stage #(
   parameter int XLEN      = 32,
   parameter int CNT_WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mem_valid,
   output logic                 mem_ready,
   input  logic [4:0]           mem_rd,
   input  logic                 mem_rd_wen,
   input  logic                 mem_is_load,
   input  logic [2:0]           mem_ld_funct3,
   input  logic [1:0]           mem_addr_lo,
   input  logic [XLEN-1:0]      mem_alu_result,
   input  logic [XLEN-1:0]      mem_load_word,
   input  logic                 hold_i,
   input  logic                 flush_i,
   output logic                 rf_wen,
   output logic [4:0]           rf_waddr,
   output logic [XLEN-1:0]      rf_wdata,
   output logic                 fwd_valid,
   output logic [4:0]           fwd_rd,
   output logic [XLEN-1:0]      fwd_data,
   output logic                 ld_err_o,
   output logic [CNT_WIDTH-1:0] instret_o
);

   logic                 valid_q;
   logic [4:0]           rd_q;
   logic                 wen_q;
   logic [XLEN-1:0]      data_q;
   logic                 err_q;
   logic [CNT_WIDTH-1:0] instret_q;

   logic                 commit;
   logic                 capture;
   logic                 ld_fault;
   logic [7:0]           ld_byte;
   logic [15:0]          ld_half;
   logic [XLEN-1:0]      ld_data;
   logic [XLEN-1:0]      cap_data;

   // Handshake: an entry moves from MEM into the stage on a clock edge where
   // mem_valid & mem_ready & !flush_i; the held entry retires (commit) on any edge
   // where it is valid and hold_i is low. mem_ready never depends on mem_valid.
   assign commit    = valid_q & ~hold_i & rst_n;
   assign mem_ready = ~valid_q | ~hold_i;
   assign capture   = mem_valid & mem_ready & ~flush_i;

   always_comb begin
      ld_byte  = 8'h00;
      ld_half  = mem_addr_lo[1] ? mem_load_word[31:16] : mem_load_word[15:0];
      ld_data  = '0;
      ld_fault = 1'b0;
      case (mem_addr_lo)
         2'd0:    ld_byte = mem_load_word[7:0];
         2'd1:    ld_byte = mem_load_word[15:8];
         2'd2:    ld_byte = mem_load_word[23:16];
         default: ld_byte = mem_load_word[31:24];
      endcase
      case (mem_ld_funct3)
         3'b000: ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
         3'b001: begin
            ld_data  = {{(XLEN-16){ld_half[15]}}, ld_half};
            ld_fault = mem_addr_lo[0];
         end
         3'b010: begin
            ld_data  = mem_load_word;
            ld_fault = (mem_addr_lo != 2'd0);
         end
         3'b100: ld_data = {{(XLEN-8){1'b0}}, ld_byte};
         3'b101: ld_data = {{(XLEN-16){1'b0}}, ld_half};
         default: ld_fault = 1'b1;
      endcase
      if (!mem_is_load)
         cap_data = mem_alu_result;
      else if (ld_fault)
         cap_data = '0;
      else
         cap_data = ld_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         rd_q      <= 5'd0;
         wen_q     <= 1'b0;
         data_q    <= '0;
         err_q     <= 1'b0;
         instret_q <= '0;
      end else begin
         err_q <= capture & mem_is_load & ld_fault;
         if (commit)
            instret_q <= instret_q + CNT_WIDTH'(1);
         if (capture) begin
            valid_q <= 1'b1;
            rd_q    <= mem_rd;
            wen_q   <= mem_rd_wen & ~(mem_is_load & ld_fault);
            data_q  <= cap_data;
         end else if (commit) begin
            valid_q <= 1'b0;
         end
      end
   end

   // Address and data are forced to zero when not writing: the regfile bypass
   // matches on address alone.
   assign rf_wen    = commit & wen_q & (rd_q != 5'd0);
   assign rf_waddr  = rf_wen ? rd_q : 5'd0;
   assign rf_wdata  = rf_wen ? data_q : '0;
   assign fwd_valid = valid_q & wen_q & (rd_q != 5'd0);
   assign fwd_rd    = rd_q;
   assign fwd_data  = data_q;
   assign ld_err_o  = err_q;
   assign instret_o = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by randomized traffic
// compared against a transaction-level model with an expected-write queue.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_valid = 1'b0;
   logic        mem_ready;
   logic [4:0]  mem_rd = 5'd0;
   logic        mem_rd_wen = 1'b0;
   logic        mem_is_load = 1'b0;
   logic [2:0]  mem_ld_funct3 = 3'd0;
   logic [1:0]  mem_addr_lo = 2'd0;
   logic [31:0] mem_alu_result = 32'd0;
   logic [31:0] mem_load_word = 32'd0;
   logic        hold_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;
   logic        ld_err_o;
   logic [63:0] instret_o;

   int n_checks = 0;
   int n_fail   = 0;

   // model state
   bit              m_valid;
   logic [4:0]      m_rd;
   bit              m_wen;
   logic [31:0]     m_data;
   bit              m_err;
   longint unsigned m_instret;
   logic [36:0]     exp_q[$];

   wb_stage #(.XLEN(32), .CNT_WIDTH(64)) dut (
      .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_rd(mem_rd), .mem_rd_wen(mem_rd_wen), .mem_is_load(mem_is_load),
      .mem_ld_funct3(mem_ld_funct3), .mem_addr_lo(mem_addr_lo),
      .mem_alu_result(mem_alu_result), .mem_load_word(mem_load_word),
      .hold_i(hold_i), .flush_i(flush_i), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
      .ld_err_o(ld_err_o), .instret_o(instret_o)
   );

   // clock / reset
   always #5 clk = ~clk;

   // load formatting from the architectural rules, using shifts and arithmetic
   function automatic void fmt_load(input logic [31:0] w, input logic [2:0] f3,
                                    input logic [1:0] a, output logic [31:0] d, output bit e);
      int unsigned b;
      int unsigned h;
      b = (w >> (8 * a)) % 256;
      h = (w >> (16 * (a / 2))) % 65536;
      d = 32'd0;
      e = 1'b0;
      case (f3)
         3'd0: d = (b >= 128) ? b + 32'hFFFF_FF00 : b;
         3'd1: if (a % 2 != 0) e = 1'b1; else d = (h >= 32768) ? h + 32'hFFFF_0000 : h;
         3'd2: if (a != 0) e = 1'b1; else d = w;
         3'd4: d = b;
         3'd5: d = h;
         default: e = 1'b1;
      endcase
   endfunction

   // advance one clock, updating the model with the inputs present at the edge
   task automatic tick();
      logic [31:0] d;
      bit e, commit, ready, cap;
      commit = m_valid && !hold_i && rst_n;
      ready  = !m_valid || !hold_i;
      cap    = mem_valid && ready && !flush_i;
      if (mem_is_load) fmt_load(mem_load_word, mem_ld_funct3, mem_addr_lo, d, e);
      else begin d = mem_alu_result; e = 1'b0; end
      @(posedge clk);
      if (!rst_n) begin
         m_valid = 0; m_rd = 0; m_wen = 0; m_data = 0; m_err = 0; m_instret = 0;
         exp_q.delete();
      end else begin
         if (commit && m_wen && m_rd != 0 && exp_q.size() > 0) void'(exp_q.pop_front());
         if (commit) m_instret++;
         m_err = cap && e;
         if (cap) begin
            m_valid = 1; m_rd = mem_rd; m_wen = mem_rd_wen && !e; m_data = d;
            if (m_wen && m_rd != 0) exp_q.push_back({m_rd, d});
         end else if (commit) m_valid = 0;
      end
      #1;
   endtask

   // driver tasks
   task automatic drive(input bit v, input logic [4:0] rd, input bit wen, input bit ld,
                        input logic [2:0] f3, input logic [1:0] a, input logic [31:0] alu,
                        input logic [31:0] word, input bit hold, input bit flush);
      mem_valid = v; mem_rd = rd; mem_rd_wen = wen; mem_is_load = ld;
      mem_ld_funct3 = f3; mem_addr_lo = a; mem_alu_result = alu; mem_load_word = word;
      hold_i = hold; flush_i = flush;
   endtask

   task automatic alu_op(input logic [4:0] rd, input logic [31:0] data);
      drive(1, rd, 1, 0, 3'd0, 2'd0, data, 32'd0, 0, 0);
   endtask

   task automatic idle();
      drive(0, 5'd0, 0, 0, 3'd0, 2'd0, 32'd0, 32'd0, 0, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; idle(); tick(); tick(); rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; idle(); tick(); tick(); rst_n = 1'b1; #1;
      n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL reset_rf_wen: got %0b want 0", rf_wen); end
      n_checks++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_rf_bus: got %0d/%h want 0/0", rf_waddr, rf_wdata); end
      n_checks++; if (fwd_valid !== 1'b0 || fwd_rd !== 5'd0 || fwd_data !== 32'd0) begin n_fail++; $display("FAIL reset_fwd: got %0b/%0d/%h want 0/0/0", fwd_valid, fwd_rd, fwd_data); end
      n_checks++; if (ld_err_o !== 1'b0 || instret_o !== 64'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0b/%0d want 0/0", ld_err_o, instret_o); end
      n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", mem_ready); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         alu_op(5'(i + 1), 32'h11 * (i + 1)); #1;
         if (i == 0) begin
            n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL b2b_first_wen: got %0b want 0", rf_wen); end
         end else begin
            n_checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'(i) || rf_wdata !== 32'h11 * i) begin n_fail++; $display("FAIL b2b_write%0d: got %0b/%0d/%h want 1/%0d/%h", i, rf_wen, rf_waddr, rf_wdata, i, 32'h11 * i); end
         end
         tick();
      end
      idle(); #1;
      n_checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h44) begin n_fail++; $display("FAIL b2b_write4: got %0b/%0d/%h want 1/4/44", rf_wen, rf_waddr, rf_wdata); end
      tick(); #1;
      n_checks++; if (instret_o !== 64'd4 || rf_wen !== 1'b0) begin n_fail++; $display("FAIL b2b_instret: got %0d/%0b want 4/0", instret_o, rf_wen); end
   endtask

   task automatic test_loads();
      logic [2:0]  f3_t[5]  = '{3'd0, 3'd4, 3'd4, 3'd1, 3'd5};
      logic [1:0]  a_t[5]   = '{2'd3, 2'd2, 2'd1, 2'd2, 2'd0};
      logic [31:0] exp_t[5] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1, 5'd10, 1, 1, f3_t[i], a_t[i], 32'h5555_5555, 32'h80FF_7F01, 0, 0);
         tick(); idle(); #1;
         n_checks++; if (rf_wen !== 1'b1 || rf_wdata !== exp_t[i] || ld_err_o !== 1'b0) begin n_fail++; $display("FAIL load%0d: got %0b/%h/%0b want 1/%h/0", i, rf_wen, rf_wdata, ld_err_o, exp_t[i]); end
         tick();
      end
   endtask

   task automatic test_misaligned();
      do_reset();
      drive(1, 5'd5, 1, 1, 3'd2, 2'd2, 32'h0, 32'h1234_5678, 0, 0);
      tick(); idle(); #1;
      n_checks++; if (ld_err_o !== 1'b1 || rf_wen !== 1'b0 || fwd_valid !== 1'b0) begin n_fail++; $display("FAIL lw_misaligned: got err %0b wen %0b fwd %0b want 1/0/0", ld_err_o, rf_wen, fwd_valid); end
      tick(); #1;
      n_checks++; if (ld_err_o !== 1'b0 || instret_o !== 64'd1) begin n_fail++; $display("FAIL lw_misaligned_after: got err %0b cnt %0d want 0/1", ld_err_o, instret_o); end
   endtask

   task automatic test_rd0();
      do_reset();
      alu_op(5'd0, 32'hDEAD); tick(); idle(); #1;
      n_checks++; if (rf_wen !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || fwd_valid !== 1'b0) begin n_fail++; $display("FAIL rd0: got %0b/%0d/%h/%0b want 0/0/0/0", rf_wen, rf_waddr, rf_wdata, fwd_valid); end
      tick(); #1;
      n_checks++; if (instret_o !== 64'd1) begin n_fail++; $display("FAIL rd0_instret: got %0d want 1", instret_o); end
   endtask

   task automatic test_hold();
      do_reset();
      alu_op(5'd7, 32'h77); tick();
      for (int i = 0; i < 3; i++) begin
         drive(1, 5'd8, 1, 0, 3'd0, 2'd0, 32'h88, 32'd0, 1, 0); #1;
         n_checks++; if (mem_ready !== 1'b0 || rf_wen !== 1'b0 || fwd_valid !== 1'b1 || fwd_rd !== 5'd7 || fwd_data !== 32'h77) begin n_fail++; $display("FAIL hold%0d: got rdy %0b wen %0b fwd %0b/%0d/%h want 0/0/1/7/77", i, mem_ready, rf_wen, fwd_valid, fwd_rd, fwd_data); end
         tick();
      end
      drive(1, 5'd8, 1, 0, 3'd0, 2'd0, 32'h88, 32'd0, 0, 0); #1;
      n_checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h77 || mem_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release: got %0b/%0d/%h rdy %0b want 1/7/77/1", rf_wen, rf_waddr, rf_wdata, mem_ready); end
      tick(); idle(); #1;
      n_checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'h88) begin n_fail++; $display("FAIL hold_next: got %0b/%0d/%h want 1/8/88", rf_wen, rf_waddr, rf_wdata); end
      tick(); #1;
      n_checks++; if (instret_o !== 64'd2) begin n_fail++; $display("FAIL hold_instret: got %0d want 2", instret_o); end
   endtask

   task automatic test_flush_and_reset();
      do_reset();
      alu_op(5'd9, 32'h99); tick();
      drive(1, 5'd10, 1, 0, 3'd0, 2'd0, 32'hAA, 32'd0, 0, 1); #1;
      n_checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h99) begin n_fail++; $display("FAIL flush_older: got %0b/%0d/%h want 1/9/99", rf_wen, rf_waddr, rf_wdata); end
      tick(); idle(); #1;
      n_checks++; if (rf_wen !== 1'b0 || fwd_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: got wen %0b fwd %0b want 0/0", rf_wen, fwd_valid); end
      alu_op(5'd11, 32'hBB); tick();
      drive(1, 5'd12, 1, 0, 3'd0, 2'd0, 32'hCC, 32'd0, 1, 1); tick();
      idle(); #1;
      n_checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd11 || rf_wdata !== 32'hBB) begin n_fail++; $display("FAIL flush_hold: got %0b/%0d/%h want 1/11/bb", rf_wen, rf_waddr, rf_wdata); end
      tick();
      alu_op(5'd3, 32'h33); tick();
      alu_op(5'd4, 32'h44); rst_n = 1'b0; #1;
      n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL reset_cycle_wen: got %0b want 0", rf_wen); end
      tick(); idle(); rst_n = 1'b1; #1;
      n_checks++; if (rf_wen !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || fwd_valid !== 1'b0 || fwd_rd !== 5'd0 || fwd_data !== 32'd0 || ld_err_o !== 1'b0 || instret_o !== 64'd0) begin n_fail++; $display("FAIL reset_mid: got wen %0b fwd %0b/%0d/%h err %0b cnt %0d want all 0", rf_wen, fwd_valid, fwd_rd, fwd_data, ld_err_o, instret_o); end
      tick();
   endtask

   task automatic test_random();
      bit          exp_wen;
      logic [36:0] exp_w;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom_range(0, 4) != 0,
               $urandom_range(0, 1) != 0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
               $urandom, $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
         rst_n = ($urandom_range(0, 59) != 0);
         #1;
         exp_wen = m_valid && m_wen && m_rd != 0 && !hold_i && rst_n;
         exp_w   = (exp_wen && exp_q.size() > 0) ? exp_q[0] : 37'd0;
         n_checks++; if (mem_ready !== (!m_valid || !hold_i)) begin n_fail++; $display("FAIL rnd_ready@%0d: got %0b", i, mem_ready); end
         n_checks++; if (rf_wen !== exp_wen || {rf_waddr, rf_wdata} !== exp_w) begin n_fail++; $display("FAIL rnd_write@%0d: got %0b/%0d/%h want %0b/%0d/%h", i, rf_wen, rf_waddr, rf_wdata, exp_wen, exp_w[36:32], exp_w[31:0]); end
         n_checks++; if (fwd_valid !== (m_valid && m_wen && m_rd != 0)) begin n_fail++; $display("FAIL rnd_fwd_valid@%0d: got %0b", i, fwd_valid); end
         if (m_valid && m_wen && m_rd != 0) begin
            n_checks++; if (fwd_rd !== m_rd || fwd_data !== m_data) begin n_fail++; $display("FAIL rnd_fwd@%0d: got %0d/%h want %0d/%h", i, fwd_rd, fwd_data, m_rd, m_data); end
         end
         n_checks++; if (ld_err_o !== m_err || instret_o !== m_instret) begin n_fail++; $display("FAIL rnd_err_cnt@%0d: got %0b/%0d want %0b/%0d", i, ld_err_o, instret_o, m_err, m_instret); end
         tick();
      end
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_loads();
      test_misaligned();
      test_rd0();
      test_hold();
      test_flush_and_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
